// File: rtl/sync_fifo_pkg.sv
// Constants shared by the sync FIFO and its read-side drain engine.
// Also provides the occupancy-counter width helper used by the prefetch buffer.
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_PTR_WIDTH  = $clog2(FIFO_DEPTH);

  // One extra bit so a completely full buffer is distinguishable from empty.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Small circular prefetch store for the stream reader.
// Supports push, pop and flush; exposes the head entry and the occupancy.
module fifo_rd_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int BUF_DEPTH  = 4,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int OCC_W     = occ_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  assign head_data = mem[head];

  // Flush empties the buffer by snapping head onto tail; stored words become stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      occ  <= '0;
      head <= tail;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, tracks the one-cycle read latency
// and re-presents the words as a valid/ready stream through a prefetch buffer.
module fifo_stream_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_wr_busy,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam int OCC_W = occ_width(BUF_DEPTH);

  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;
  logic             rd_accept;
  logic             push;
  logic             pop;

  // Reserve a slot for the word still in flight so the buffer can never overflow.
  assign pending    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (pending < (OCC_W+1)'(BUF_DEPTH));
  assign rd_accept  = fifo_rd_en && !fifo_empty && !fifo_wr_busy;

  assign m_valid = (occ != '0);
  assign push    = inflight && !flush;
  assign pop     = m_valid && m_ready && !flush;

  // The FIFO's data_out is registered, so an accepted read lands one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      beat_count <= '0;
    end else begin
      inflight <= rd_accept;
      if (pop) begin
        beat_count <= beat_count + CNT_WIDTH'(1);
      end
    end
  end

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural sync FIFO in front
// and an in-order beat scoreboard behind it.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_wr_busy;
  logic [7:0]  fifo_data = '0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        flush;
  logic [15:0] beat_count;

  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  fq[$];
  int          fcount = 0;
  int          rdAccepts = 0;
  logic [7:0]  expq[$];
  int          assertCount = 0;
  int          failCount = 0;
  int          rdBase;

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_wr_busy (fifo_wr_busy),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .flush        (flush),
    .beat_count   (beat_count)
  );

  // Behavioural FIFO: writes win over reads, data_out registered one cycle after a read.
  assign fifo_empty   = (fcount == 0);
  assign fifo_wr_busy = wr_en;

  always @(posedge clk) begin
    if (wr_en) begin
      fq.push_back(wr_data);
      fcount <= fcount + 1;
    end else if (fifo_rd_en && fcount != 0) begin
      fifo_data <= fq.pop_front();
      fcount    <= fcount - 1;
      rdAccepts++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic ready, input logic fl);
    wr_en   = wr;
    wr_data = data;
    m_ready = ready;
    flush   = fl;
  endtask

  task automatic midCycle;
    #4;
  endtask

  // Scoreboard every delivered beat at the negedge, then move to just after the next posedge.
  task automatic endCycle;
    if (!rst && !flush && m_valid && m_ready) begin
      if (expq.size() == 0) checkOutput("unexpected-beat", {24'h0, m_data}, 32'hFFFF_FFFF);
      else                  checkOutput("beat-data", {24'h0, m_data}, {24'h0, expq.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick;
    midCycle;
    endCycle;
  endtask

  task automatic drainExpected(input int budget, input string tag);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick;
      n++;
    end
    checkOutput(tag, expq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset state while the FIFO is preloaded with 0x11..0x18
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    midCycle;
    checkOutput("reset-m_valid", m_valid, 1'b0);
    checkOutput("reset-m_data", m_data, 8'h00);
    checkOutput("reset-rd_en", fifo_rd_en, 1'b0);
    checkOutput("reset-beat_count", beat_count, 16'd0);
    endCycle;

    // Streaming: rd_en in cycle 0, first valid in cycle 2, eight beats back to back
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) expq.push_back(8'(8'h11 + i));
    midCycle;
    checkOutput("c0-rd_en", fifo_rd_en, 1'b1);
    checkOutput("c0-m_valid", m_valid, 1'b0);
    endCycle;
    midCycle;
    checkOutput("c1-m_valid", m_valid, 1'b0);
    endCycle;
    for (int c = 2; c < 10; c++) begin
      midCycle;
      checkOutput("stream-m_valid", m_valid, 1'b1);
      if (c == 2) checkOutput("c2-m_data", m_data, 8'h11);
      endCycle;
    end
    midCycle;
    checkOutput("stream-end-m_valid", m_valid, 1'b0);
    checkOutput("stream-end-rd_en", fifo_rd_en, 1'b0);
    checkOutput("stream-beat_count", beat_count, 16'd8);
    checkOutput("stream-leftover", expq.size(), 0);
    endCycle;

    // Stall: only BUF_DEPTH reads accepted, head data held
    rdBase = rdAccepts;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick;
    checkOutput("stall-reads", rdAccepts - rdBase, 4);
    for (int i = 0; i < 3; i++) begin
      midCycle;
      checkOutput("stall-rd_en", fifo_rd_en, 1'b0);
      checkOutput("stall-m_valid", m_valid, 1'b1);
      checkOutput("stall-m_data", m_data, 8'h21);
      endCycle;
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) expq.push_back(8'(8'h21 + i));
    drainExpected(20, "stall-drain");
    checkOutput("stall-beat_count", beat_count, 16'd16);

    // Writer busy: three back-to-back writes then alternate-cycle writes
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h31 + i), 1'b1, 1'b0);
      expq.push_back(8'(8'h31 + i));
      tick;
    end
    for (int i = 3; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h31 + i), 1'b1, 1'b0);
      expq.push_back(8'(8'h31 + i));
      tick;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick;
    end
    drainExpected(20, "wrbusy-drain");
    tick;
    checkOutput("wrbusy-beat_count", beat_count, 16'd22);

    // Empty FIFO: idle, then a single new word resumes the stream
    midCycle;
    checkOutput("empty-m_valid", m_valid, 1'b0);
    checkOutput("empty-rd_en", fifo_rd_en, 1'b0);
    endCycle;
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
    expq.push_back(8'h41);
    tick;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    midCycle;
    checkOutput("resume-rd_en", fifo_rd_en, 1'b1);
    endCycle;
    midCycle;
    checkOutput("resume-m_valid-early", m_valid, 1'b0);
    endCycle;
    midCycle;
    checkOutput("resume-m_valid", m_valid, 1'b1);
    checkOutput("resume-m_data", m_data, 8'h41);
    endCycle;
    drainExpected(5, "resume-drain");
    checkOutput("resume-beat_count", beat_count, 16'd23);

    // Flush with occ=3 and one word landing: 0x51..0x54 dropped
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    midCycle;
    checkOutput("flush-m_valid", m_valid, 1'b1);
    checkOutput("flush-m_data", m_data, 8'h51);
    checkOutput("flush-rd_en", fifo_rd_en, 1'b0);
    endCycle;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    midCycle;
    checkOutput("postflush-m_valid", m_valid, 1'b0);
    checkOutput("postflush-rd_en", fifo_rd_en, 1'b1);
    checkOutput("postflush-beat_count", beat_count, 16'd23);
    for (int i = 4; i < 8; i++) expq.push_back(8'(8'h51 + i));
    endCycle;
    drainExpected(20, "flush-drain");
    checkOutput("flush-beat_count", beat_count, 16'd27);

    // Reset during a full stall
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick;
    midCycle;
    checkOutput("prerst-m_valid", m_valid, 1'b1);
    checkOutput("prerst-m_data", m_data, 8'h61);
    checkOutput("prerst-rd_en", fifo_rd_en, 1'b0);
    endCycle;
    rst = 1'b1;
    tick;
    midCycle;
    checkOutput("rst-m_valid", m_valid, 1'b0);
    checkOutput("rst-m_data", m_data, 8'h00);
    checkOutput("rst-beat_count", beat_count, 16'd0);
    checkOutput("rst-rd_en", fifo_rd_en, 1'b0);
    endCycle;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expq.push_back(8'h65);
    expq.push_back(8'h66);
    drainExpected(10, "rst-drain");
    checkOutput("rst-beat_count-after", beat_count, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
